// File: rtl/csr_pkg.sv
// Shared types and helpers for the dense-to-CSR frame encoder.
package csr_pkg;

  typedef enum logic {FILL, EMIT} csr_enc_state_t;

  // Widest element the zero test accepts; callers zero-extend to this width.
  localparam int unsigned MAX_X_WIDTH = 64;

  // Width of an exclusive prefix sum over m one-bit flags (must hold the value m).
  function automatic int unsigned prefix_width(input int unsigned m);
    return $clog2(m + 1);
  endfunction

  function automatic logic is_nonzero(input logic [MAX_X_WIDTH-1:0] value);
    return |value;
  endfunction

endpackage

// File: rtl/csr_row_compactor.sv
// Packs the nonzeros of one dense row, in ascending column order, into NZN_ROW slots.
module csr_row_compactor
  import csr_pkg::*;
#(
  parameter int M          = 2,
  parameter int X_WIDTH    = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int NZN_ROW    = 2,
  localparam int CW        = prefix_width(M)
) (
  input  logic [X_WIDTH-1:0]    row_data   [0:M-1],
  output logic [X_WIDTH-1:0]    kept_data  [0:NZN_ROW-1],
  output logic [ADDR_WIDTH-1:0] kept_col   [0:NZN_ROW-1],
  output logic [CW-1:0]         kept_count,
  output logic                  row_trunc
);

  // off is the exclusive prefix sum of nonzero flags, i.e. the slot of the current element.
  always_comb begin
    logic [CW-1:0] off;
    off       = '0;
    row_trunc = 1'b0;
    for (int k = 0; k < NZN_ROW; k++) begin
      kept_data[k] = '0;
      kept_col[k]  = '0;
    end
    for (int m = 0; m < M; m++) begin
      if (is_nonzero(MAX_X_WIDTH'(row_data[m]))) begin
        for (int k = 0; k < NZN_ROW; k++) begin
          if (off == CW'(k)) begin
            kept_data[k] = row_data[m];
            kept_col[k]  = ADDR_WIDTH'(m);
          end
        end
        if (off >= CW'(NZN_ROW)) row_trunc = 1'b1;
        off = off + CW'(1);
      end
    end
    kept_count = (off > CW'(NZN_ROW)) ? CW'(NZN_ROW) : off;
  end

endmodule

// File: rtl/csr_dense_encoder.sv
// Accumulates N dense rows into one CSR frame and hands it out on a valid/ready port.
module csr_dense_encoder
  import csr_pkg::*;
#(
  parameter int N          = 2,
  parameter int M          = 2,
  parameter int X_WIDTH    = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int NZN        = 4,
  parameter int NZN_ROW    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [X_WIDTH-1:0]    in_data       [0:M-1],
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [X_WIDTH-1:0]    out_data      [0:NZN-1],
  output logic [ADDR_WIDTH-1:0] out_col_index [0:NZN-1],
  output logic [ADDR_WIDTH-1:0] out_row_bound [0:N],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_overflow
);

  localparam int CW = prefix_width(M);
  localparam int RW = $clog2(N + 1);
  localparam int PW = $clog2(NZN + 1);

  csr_enc_state_t        state_q, state_d;
  logic [RW-1:0]         row_q, row_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [X_WIDTH-1:0]    data_q  [0:NZN-1];
  logic [X_WIDTH-1:0]    data_d  [0:NZN-1];
  logic [ADDR_WIDTH-1:0] col_q   [0:NZN-1];
  logic [ADDR_WIDTH-1:0] col_d   [0:NZN-1];
  logic [ADDR_WIDTH-1:0] bound_q [0:N];
  logic [ADDR_WIDTH-1:0] bound_d [0:N];
  logic                  ovf_q, ovf_d;

  logic [X_WIDTH-1:0]    kept_data [0:NZN_ROW-1];
  logic [ADDR_WIDTH-1:0] kept_col  [0:NZN_ROW-1];
  logic [CW-1:0]         kept_count;
  logic                  row_trunc;

  csr_row_compactor #(
    .M          (M),
    .X_WIDTH    (X_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NZN_ROW    (NZN_ROW)
  ) u_row (
    .row_data   (in_data),
    .kept_data  (kept_data),
    .kept_col   (kept_col),
    .kept_count (kept_count),
    .row_trunc  (row_trunc)
  );

  // keep is the row's compacted count clamped to the space left in the frame.
  always_comb begin
    int room;
    int keep;
    state_d = state_q;
    row_d   = row_q;
    wptr_d  = wptr_q;
    data_d  = data_q;
    col_d   = col_q;
    bound_d = bound_q;
    ovf_d   = ovf_q;
    room    = NZN - int'(wptr_q);
    keep    = (int'(kept_count) < room) ? int'(kept_count) : room;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          for (int s = 0; s < NZN; s++) begin
            for (int j = 0; j < NZN_ROW; j++) begin
              if (j < keep && s == int'(wptr_q) + j) begin
                data_d[s] = kept_data[j];
                col_d[s]  = kept_col[j];
              end
            end
          end
          wptr_d = wptr_q + PW'(keep);
          for (int r = 0; r < N; r++) begin
            if (int'(row_q) == r) bound_d[r+1] = ADDR_WIDTH'(wptr_d);
          end
          ovf_d = ovf_q | row_trunc | (int'(kept_count) > room);
          if (int'(row_q) == N - 1) state_d = EMIT;
          else                      row_d   = row_q + RW'(1);
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_d = FILL;
          row_d   = '0;
          wptr_d  = '0;
          ovf_d   = 1'b0;
          for (int s = 0; s < NZN; s++) begin
            data_d[s] = '0;
            col_d[s]  = '0;
          end
          for (int r = 0; r <= N; r++) bound_d[r] = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      row_q   <= '0;
      wptr_q  <= '0;
      ovf_q   <= 1'b0;
      for (int s = 0; s < NZN; s++) begin
        data_q[s] <= '0;
        col_q[s]  <= '0;
      end
      for (int r = 0; r <= N; r++) bound_q[r] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      wptr_q  <= wptr_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      col_q   <= col_d;
      bound_q <= bound_d;
    end
  end

  assign in_ready      = (state_q == FILL);
  assign out_valid     = (state_q == EMIT);
  assign out_data      = data_q;
  assign out_col_index = col_q;
  assign out_row_bound = bound_q;
  assign out_overflow  = ovf_q;

endmodule

// File: tb/tb_csr_dense_encoder.sv
// Randomized self-checking bench: a default-size encoder plus a 3x3 one that exercises both caps.
module tb_csr_dense_encoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  a_in_data [0:1];
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf;
  logic [7:0]  a_out_data [0:3];
  logic [15:0] a_out_col  [0:3];
  logic [15:0] a_bound    [0:2];

  logic [7:0]  b_in_data [0:2];
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf;
  logic [7:0]  b_out_data [0:3];
  logic [15:0] b_out_col  [0:3];
  logic [15:0] b_bound    [0:3];

  int vectors    = 0;
  int miscompares = 0;

  csr_dense_encoder #(.N(2), .M(2), .X_WIDTH(8), .ADDR_WIDTH(16), .NZN(4), .NZN_ROW(2)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_col_index(a_out_col), .out_row_bound(a_bound),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_overflow(a_ovf)
  );

  csr_dense_encoder #(.N(3), .M(3), .X_WIDTH(8), .ADDR_WIDTH(16), .NZN(4), .NZN_ROW(2)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_col_index(b_out_col), .out_row_bound(b_bound),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_overflow(b_ovf)
  );

  // Frame image: data at 8*i, column at 8*NZN+16*i, bound r at 24*NZN+16*r, overflow after the bounds.
  logic [255:0] a_flat, b_flat;
  always_comb begin
    a_flat = '0;
    for (int i = 0; i < 4; i++) begin
      a_flat[i*8 +: 8]       = a_out_data[i];
      a_flat[32 + i*16 +: 16] = a_out_col[i];
    end
    for (int r = 0; r < 3; r++) a_flat[96 + r*16 +: 16] = a_bound[r];
    a_flat[144] = a_ovf;
  end
  always_comb begin
    b_flat = '0;
    for (int i = 0; i < 4; i++) begin
      b_flat[i*8 +: 8]       = b_out_data[i];
      b_flat[32 + i*16 +: 16] = b_out_col[i];
    end
    for (int r = 0; r < 4; r++) b_flat[96 + r*16 +: 16] = b_bound[r];
    b_flat[160] = b_ovf;
  end

  // Reference CSR encode: walk each row's nonzeros left to right, keep while under both caps.
  function automatic logic [255:0] model(input int n, input int m, input int nzn, input int nzr,
                                         input int rows[16]);
    logic [255:0] f;
    int w;
    bit ovf;
    f   = '0;
    w   = 0;
    ovf = 0;
    for (int r = 0; r < n; r++) begin
      int kr;
      kr = 0;
      for (int c = 0; c < m; c++) begin
        if (rows[r*m + c] != 0) begin
          if (kr < nzr && w < nzn) begin
            f[w*8 +: 8]              = 8'(rows[r*m + c]);
            f[nzn*8 + w*16 +: 16]    = 16'(c);
            w++;
            kr++;
          end else begin
            ovf = 1;
          end
        end
      end
      f[nzn*24 + (r+1)*16 +: 16] = 16'(w);
    end
    f[nzn*24 + (n+1)*16] = ovf;
    return f;
  endfunction

  function automatic int rnd_elem();
    return ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 255)) : 0;
  endfunction

  task automatic drive_row_a(input int d0, input int d1);
    int waited;
    waited = 0;
    @(negedge clk);
    a_in_data[0] = 8'(d0);
    a_in_data[1] = 8'(d1);
    a_in_valid   = 1'b1;
    while (a_in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (waited >= 20) begin
      miscompares++;
      $display("[TB] FAIL row_accept_a in_ready=%b required 1", a_in_ready);
    end
    @(posedge clk);
    #1 a_in_valid = 1'b0;
  endtask

  task automatic drive_row_b(input int d0, input int d1, input int d2);
    int waited;
    waited = 0;
    @(negedge clk);
    b_in_data[0] = 8'(d0);
    b_in_data[1] = 8'(d1);
    b_in_data[2] = 8'(d2);
    b_in_valid   = 1'b1;
    while (b_in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (waited >= 20) begin
      miscompares++;
      $display("[TB] FAIL row_accept_b in_ready=%b required 1", b_in_ready);
    end
    @(posedge clk);
    #1 b_in_valid = 1'b0;
  endtask

  task automatic consume_a();
    @(negedge clk);
    a_out_ready = 1'b1;
    @(posedge clk);
    #1 a_out_ready = 1'b0;
  endtask

  task automatic consume_b();
    @(negedge clk);
    b_out_ready = 1'b1;
    @(posedge clk);
    #1 b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (a_flat !== '0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_a got=%h valid=%b ready=%b required zero frame, valid 0, ready 1",
               a_flat, a_out_valid, a_in_ready);
    end
    vectors++;
    if (b_flat !== '0 || b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_b got=%h valid=%b ready=%b required zero frame, valid 0, ready 1",
               b_flat, b_out_valid, b_in_ready);
    end
  endtask

  task automatic test_dense();
    int rows[16];
    logic [255:0] exp;
    rows = '{default: 0};
    rows[0] = 3; rows[1] = 5; rows[2] = 7; rows[3] = 9;
    exp = model(2, 2, 4, 2, rows);
    drive_row_a(3, 5);
    @(negedge clk);
    vectors++;
    if (a_out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL dense_early_valid got=%b required 0", a_out_valid);
    end
    drive_row_a(7, 9);
    @(negedge clk);
    vectors++;
    if (a_out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL dense_latency got=%b required 1", a_out_valid);
    end
    vectors++;
    if (a_flat !== exp) begin
      miscompares++;
      $display("[TB] FAIL dense_frame got=%h exp=%h", a_flat, exp);
    end
    consume_a();
    @(negedge clk);
    vectors++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_flat !== '0) begin
      miscompares++;
      $display("[TB] FAIL dense_handoff_clear got=%h ready=%b valid=%b required zero, 1, 0",
               a_flat, a_in_ready, a_out_valid);
    end
  endtask

  task automatic test_sparse();
    int rows[16];
    logic [255:0] exp;
    rows = '{default: 0};
    rows[1] = 4;
    exp = model(2, 2, 4, 2, rows);
    drive_row_a(0, 4);
    drive_row_a(0, 0);
    @(negedge clk);
    vectors++;
    if (a_out_valid !== 1'b1 || a_flat !== exp) begin
      miscompares++;
      $display("[TB] FAIL sparse_frame got=%h valid=%b exp=%h", a_flat, a_out_valid, exp);
    end
    consume_a();
  endtask

  task automatic test_back_to_back();
    int rows[16];
    logic [255:0] exp;
    for (int f = 0; f < 2; f++) begin
      rows = '{default: 0};
      for (int i = 0; i < 4; i++) rows[i] = rnd_elem();
      exp = model(2, 2, 4, 2, rows);
      drive_row_a(rows[0], rows[1]);
      drive_row_a(rows[2], rows[3]);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        a_in_valid   = 1'b1;
        a_in_data[0] = 8'($urandom_range(1, 255));
        a_in_data[1] = 8'($urandom_range(1, 255));
        vectors++;
        if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_flat !== exp) begin
          miscompares++;
          $display("[TB] FAIL backpressure_hold got=%h valid=%b ready=%b exp=%h",
                   a_flat, a_out_valid, a_in_ready, exp);
        end
      end
      consume_a();
      a_in_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (a_in_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL backpressure_release got=%b required 1", a_in_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    int rows[16];
    logic [255:0] exp;
    rows = '{default: 0};
    rows[0] = 1; rows[3] = 2;
    exp = model(2, 2, 4, 2, rows);
    drive_row_a(8, 8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (a_flat !== '0 || a_in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset_clear got=%h ready=%b required zero, 1", a_flat, a_in_ready);
    end
    drive_row_a(1, 0);
    drive_row_a(0, 2);
    @(negedge clk);
    vectors++;
    if (a_out_valid !== 1'b1 || a_flat !== exp) begin
      miscompares++;
      $display("[TB] FAIL midreset_frame got=%h valid=%b exp=%h", a_flat, a_out_valid, exp);
    end
    consume_a();
  endtask

  task automatic test_row_cap();
    int rows[16];
    logic [255:0] exp;
    for (int f = 0; f < 8; f++) begin
      rows = '{default: 0};
      if (f == 0) begin
        rows[0] = 1; rows[1] = 2; rows[2] = 3; rows[5] = 6;
      end else if (f == 1) begin
        rows[0] = 1; rows[2] = 2; rows[3] = 3; rows[4] = 4; rows[6] = 5;
      end else begin
        for (int i = 0; i < 9; i++) rows[i] = rnd_elem();
      end
      exp = model(3, 3, 4, 2, rows);
      drive_row_b(rows[0], rows[1], rows[2]);
      drive_row_b(rows[3], rows[4], rows[5]);
      drive_row_b(rows[6], rows[7], rows[8]);
      @(negedge clk);
      vectors++;
      if (b_out_valid !== 1'b1 || b_flat !== exp) begin
        miscompares++;
        $display("[TB] FAIL cap_frame_%0d got=%h valid=%b exp=%h", f, b_flat, b_out_valid, exp);
      end
      consume_b();
    end
  endtask

  task automatic test_streaming();
    int rows[16];
    int srows[16];
    logic [255:0] exps[4];
    int next, seen, last;
    for (int f = 0; f < 4; f++) begin
      rows = '{default: 0};
      for (int i = 0; i < 4; i++) begin
        rows[i]          = rnd_elem();
        srows[f*4 + i]   = rows[i];
      end
      exps[f] = model(2, 2, 4, 2, rows);
    end
    next = 0;
    seen = 0;
    last = 0;
    a_out_ready = 1'b1;
    for (int c = 0; c < 60 && seen < 4; c++) begin
      @(negedge clk);
      if (a_out_valid === 1'b1) begin
        vectors++;
        if (a_flat !== exps[seen]) begin
          miscompares++;
          $display("[TB] FAIL stream_frame_%0d got=%h exp=%h", seen, a_flat, exps[seen]);
        end
        if (seen > 0) begin
          vectors++;
          if (c - last != 3) begin
            miscompares++;
            $display("[TB] FAIL stream_period got=%0d required 3", c - last);
          end
        end
        last = c;
        seen++;
      end
      if (a_in_ready === 1'b1) begin
        if (next < 8) begin
          a_in_data[0] = 8'(srows[next*2]);
          a_in_data[1] = 8'(srows[next*2 + 1]);
          a_in_valid   = 1'b1;
          next++;
        end else begin
          a_in_valid = 1'b0;
        end
      end
    end
    a_out_ready = 1'b0;
    a_in_valid  = 1'b0;
    vectors++;
    if (seen != 4) begin
      miscompares++;
      $display("[TB] FAIL stream_count got=%0d required 4", seen);
    end
    if (a_out_valid === 1'b1) consume_a();
  endtask

  initial begin
    rst          = 1'b1;
    a_in_valid   = 1'b0;
    a_out_ready  = 1'b0;
    b_in_valid   = 1'b0;
    b_out_ready  = 1'b0;
    a_in_data[0] = '0; a_in_data[1] = '0;
    b_in_data[0] = '0; b_in_data[1] = '0; b_in_data[2] = '0;
    test_reset();
    test_dense();
    test_sparse();
    test_back_to_back();
    test_reset_mid();
    test_row_cap();
    test_streaming();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
